// File: rtl/buffer_pkg.sv
// Shared defaults for the line buffer hierarchy and a helper that sizes the column counter.
package buffer_pkg;

    localparam int unsigned DefPixelWidth   = 1;
    localparam int unsigned DefImageWidth   = 640;
    localparam int unsigned DefAddrWidth    = 10;
    localparam int unsigned DefWindowHeight = 3;
    localparam int unsigned DefRowWidth     = 9;

    // Smallest counter width that can address every column of a line.
    function automatic int unsigned min_addr_width(input int unsigned width);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(width)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One stored image line: single port, synchronous write, registered read-old-data.
module line_ram
    import buffer_pkg::*;
#(
    parameter int unsigned PixelWidth = DefPixelWidth,
    parameter int unsigned Depth      = DefImageWidth,
    parameter int unsigned AddrWidth  = DefAddrWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [AddrWidth-1:0]  addr_i,
    input  logic [PixelWidth-1:0] wdata_i,
    output logic [PixelWidth-1:0] old_o,
    output logic [PixelWidth-1:0] rdata_o
);

    logic [PixelWidth-1:0] mem_q [Depth];
    logic [PixelWidth-1:0] rdata_q, rdata_d;

    // Pre-write contents at the addressed slot; feeds the next line's write cascade.
    assign old_o = mem_q[addr_i];

    always_comb begin
        rdata_d = rdata_q;
        if (we_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_window_buffer.sv
// Raster stream to vertical pixel columns: raster counters, line RAM cascade, output registers.
module line_window_buffer
    import buffer_pkg::*;
#(
    parameter int unsigned PixelWidth   = DefPixelWidth,
    parameter int unsigned ImageWidth   = DefImageWidth,
    parameter int unsigned AddrWidth    = DefAddrWidth,
    parameter int unsigned WindowHeight = DefWindowHeight,
    parameter int unsigned RowWidth     = DefRowWidth
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               FrameStart,
    input  logic                               PixelValid,
    input  logic [PixelWidth-1:0]              PixelIn,
    output logic                               ColumnValid,
    output logic [WindowHeight*PixelWidth-1:0] ColumnOut,
    output logic [AddrWidth-1:0]               OutX,
    output logic [RowWidth-1:0]                OutY
);

    localparam int unsigned NumLines = WindowHeight - 1;

    if (AddrWidth < min_addr_width(ImageWidth)) begin : g_bad_addr_width
        $error("AddrWidth too narrow for ImageWidth");
    end

    logic [AddrWidth-1:0]  col_q, col_d, eff_col;
    logic [RowWidth-1:0]   row_q, row_d, eff_row;
    logic [PixelWidth-1:0] pix_q, pix_d;
    logic [AddrWidth-1:0]  out_x_q, out_x_d;
    logic [RowWidth-1:0]   out_y_q, out_y_d;
    logic                  valid_q, valid_d;
    logic                  ram_we;

    logic [PixelWidth-1:0] ram_old   [NumLines];
    logic [PixelWidth-1:0] ram_rdata [NumLines];

    assign ram_we = PixelValid & ~Reset;

    for (genvar g = 0; g < NumLines; g++) begin : g_line
        logic [PixelWidth-1:0] wdata;
        if (g == 0) begin : g_head
            assign wdata = PixelIn;
        end else begin : g_tail
            assign wdata = ram_old[g-1];
        end

        line_ram #(
            .PixelWidth (PixelWidth),
            .Depth      (ImageWidth),
            .AddrWidth  (AddrWidth)
        ) u_line_ram (
            .clk_i   (Clock),
            .rst_i   (Reset),
            .we_i    (ram_we),
            .addr_i  (eff_col),
            .wdata_i (wdata),
            .old_o   (ram_old[g]),
            .rdata_o (ram_rdata[g])
        );
    end

    always_comb begin
        eff_col = FrameStart ? '0 : col_q;
        eff_row = FrameStart ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        pix_d   = pix_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        valid_d = 1'b0;
        if (PixelValid) begin
            pix_d   = PixelIn;
            out_x_d = eff_col;
            out_y_d = eff_row;
            valid_d = (eff_row >= RowWidth'(WindowHeight - 1));
            if (eff_col == AddrWidth'(ImageWidth - 1)) begin
                col_d = '0;
                row_d = (eff_row == {RowWidth{1'b1}}) ? eff_row : eff_row + 1'b1;
            end else begin
                col_d = eff_col + 1'b1;
                row_d = eff_row;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            valid_q <= valid_d;
        end
    end

    // Slice 0 is the live pixel; slice i is what line RAM i-1 held for this column.
    always_comb begin
        ColumnOut = '0;
        ColumnOut[PixelWidth-1:0] = pix_q;
        for (int i = 1; i < WindowHeight; i++) begin
            ColumnOut[i*PixelWidth +: PixelWidth] = ram_rdata[i-1];
        end
    end

    assign ColumnValid = valid_q;
    assign OutX        = out_x_q;
    assign OutY        = out_y_q;

endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised multi-line pixel buffer that turns a raster-order pixel stream into vertical columns of `WindowHeight` vertically adjacent pixels. Downstream K×K neighbourhood filters (morphology, convolution) consume these columns. It generalises the single-line 1-bit buffer in three ways: pixel width, number of stored lines and raster position tracking are all parameters. It also adds stream-valid gating, frame restart and output-valid qualification. It sits between the pixel input stage and the window/filter stage of the `Buffer` hierarchy.

## Interface
- `PixelWidth`, 1: bits per pixel.
- `ImageWidth`, 640: pixels per line.
- `AddrWidth`, 10: column counter width. Requires 2^AddrWidth ≥ ImageWidth.
- `WindowHeight`, 3: rows per output column. Range ≥ 2. `WindowHeight-1` lines are stored.
- `RowWidth`, 9: row counter width.

Ports:
- `Clock`  in  1: single clock; all logic on its rising edge.
- `Reset`  in  1: synchronous, active-high.
- `FrameStart`  in  1: restart the raster at column 0, row 0. Qualified by `PixelValid`.
- `PixelValid`  in  1: `PixelIn` carries a pixel this cycle.
- `PixelIn`  in  PixelWidth: current pixel.
- `ColumnValid`  out  1: `ColumnOut` holds a fully populated column.
- `ColumnOut`  out  WindowHeight*PixelWidth: slice 0 is the current row; slice WindowHeight-1 is the oldest row.
- `OutX`  out  AddrWidth: column of the pixel in `ColumnOut` slice 0.
- `OutY`  out  RowWidth: row of the pixel in `ColumnOut` slice 0.

## Operation
- Internal counters: `Col` (0..ImageWidth-1) and `Row` (saturating at 2^RowWidth-1).
- Accepted pixel: `PixelValid`=1.
  - Effective position is (0,0) if `FrameStart`=1, otherwise (`Col`,`Row`).
  - All line RAMs are read at address `Col`. Read-during-write returns the old data.
  - Line RAM 0 writes `PixelIn`. Line RAM i writes the old data read from RAM i-1. This cascade shifts each column up one row.
  - `Col` increments. When `Col` passes ImageWidth-1 it wraps to 0 and `Row` increments (saturating).
  - After `FrameStart`, the counters advance from (0,0): next position is (1,0).
- No pixel: `PixelValid`=0 means no RAM write, counters hold and `ColumnOut`/`OutX`/`OutY` hold. `FrameStart` is ignored.
- Valid rule: `ColumnValid` is 1 only for accepted pixels whose effective row ≥ WindowHeight-1. Rows 0..WindowHeight-2 are filling and produce no valid output.
- RAM contents are not cleared by `Reset` or `FrameStart`. Stale data is masked by the valid rule.

## Timing
- Latency: 1 cycle from the accepted pixel to `ColumnOut`/`ColumnValid`/`OutX`/`OutY`. `PixelIn` is registered alongside the registered RAM reads.
- `ColumnValid` is a single-cycle pulse per accepted pixel. There is no backpressure.
- Reset values:
  - `ColumnValid`=0, `ColumnOut`=0, `OutX`=0, `OutY`=0.
  - `Col`=0, `Row`=0.
- `Reset` overrides `FrameStart` and `PixelValid` in the same cycle. The pixel is dropped.
- Reset or `FrameStart` mid-line: the partial line is abandoned. Filling restarts and `WindowHeight-1` full lines must be re-streamed before `ColumnValid` returns.
- Back-to-back pixels are sustained at 1 pixel per clock.
- Line wrap: the column at `Col`=ImageWidth-1 and the next column at `Col`=0 are emitted on consecutive cycles with no bubble.

## Structure
- Shared package/header `buffer_pkg` holds:
  - default `PixelWidth`, `ImageWidth`, `AddrWidth`, `WindowHeight`, `RowWidth`;
  - a width-check function that returns the minimum address width for `ImageWidth`.
- Sub-module `line_ram`:
  - one line of `ImageWidth` × `PixelWidth`, single port;
  - synchronous write-enable, registered read, read-old-data on collision;
  - instantiated `WindowHeight-1` times by generate loop.
- Top level holds the counters, the write cascade, the output registers and the valid logic.

## Test plan
Bench configuration: `PixelWidth`=8, `ImageWidth`=4, `AddrWidth`=2, `WindowHeight`=3. Pixel value = row*16+col.

1. Reset asserted 2 cycles with `PixelValid`=1 → all outputs 0, no writes.
2. Stream rows 0..2 continuously:
   - `ColumnValid`=0 throughout rows 0–1;
   - one cycle after pixel 0x21 → `ColumnOut`={0x01,0x11,0x21} (oldest..current), `OutX`=1, `OutY`=2, `ColumnValid`=1.
3. `PixelValid` low for 2 cycles mid-row 2 → `ColumnValid`=0, outputs and counters hold. Resume → next column is correct, with no skipped or duplicated column.
4. Row 2 col 3 followed immediately by row 3 col 0 → consecutive valid cycles:
   - `OutX`=3, `OutY`=2, then `OutX`=0, `OutY`=3;
   - second column = {0x10,0x20,0x30}.
5. `FrameStart` with pixel 0xAA at row 3 col 2:
   - output `OutX`=0, `OutY`=0, `ColumnValid`=0;
   - next accepted pixel reports `OutX`=1;
   - `ColumnValid` stays 0 until effective row 2.
6. `Reset` and `FrameStart` in the same cycle mid-row → reset values. Re-streaming rows 0..2 reproduces scenario 2 exactly.
